cpu_boot_sequencer: RTL
=======================

Name: cpu_boot_sequencer

Overview:
Top-level run controller for the single-cycle MIPS CPU (MipsCPU).
- Holds the CPU in reset.
- Streams a program image into the instruction memory write port.
- Releases the CPU for a programmed number of cycles, or until a halt request, then parks it back in reset.
- Replaces bench-side memory preloading, so directed and system tests share one boot path.

Parameters:
ADDR_W, 8, instruction memory word-address width; depth = 2**ADDR_W words
DATA_W, 32, instruction word width
CNT_W, 16, run-cycle counter width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  reset, synchronous and active-low
load_start  in  1  pulse: begin a load phase (honoured in IDLE and DONE only)
ld_valid  in  1  load stream word valid
ld_ready  out  1  load stream ready
ld_data  in  DATA_W  load stream instruction word
ld_last  in  1  marks final word of image
halt_req  in  1  abort load or stop run
run_cycles  in  CNT_W  run length; 0 = run until halt_req
im_we  out  1  instruction memory write enable
im_addr  out  ADDR_W  instruction memory word address
im_wdata  out  DATA_W  instruction memory write data
cpu_reset  out  1  active-low reset to MipsCPU
busy  out  1  high in LOAD, ARM, RUN
done  out  1  high in DONE
words_loaded  out  ADDR_W+1  words written in last load
cycle_count  out  CNT_W  cycles CPU spent out of reset in last run

Behaviour:
- Synchronous active-low reset: state=IDLE; cpu_reset=0, ld_ready=0, im_we=0, im_addr=0, busy=0, done=0, words_loaded=0, cycle_count=0.
- Reset asserted mid-LOAD or mid-RUN takes effect at the next edge. cpu_reset=0 in that cycle; no further im_we.
- States: IDLE, LOAD, ARM, RUN, DONE.
- IDLE: cpu_reset=0.
  - load_start -> LOAD; clears wr pointer, words_loaded, cycle_count.
- LOAD: ld_ready=1 while words_loaded < 2**ADDR_W.
  - Beat = ld_valid & ld_ready.
  - im_we = beat (combinational); im_addr = wr pointer; im_wdata = ld_data.
  - Zero-latency write: the word is written on the same edge it is accepted.
  - Each beat increments the pointer and words_loaded.
  - Exits:
    - beat with ld_last -> ARM.
    - Beat filling the last address (words_loaded becomes 2**ADDR_W) -> ARM, even without ld_last. Further words are not accepted.
    - halt_req -> IDLE; words_loaded retained.
    - halt_req and a beat in the same cycle: the beat is written, then go to IDLE. Halt has priority over ARM.
  - load_start in LOAD is ignored.
- ARM: exactly 1 cycle.
  - cpu_reset=0, ld_ready=0.
  - Latch run_cycles into limit; cycle_count=0.
  - Go to RUN.
- RUN: cpu_reset=1.
  - cycle_count increments each cycle; saturates at 2**CNT_W-1 (free-run only).
  - limit!=0: when cycle_count==limit-1 -> DONE. cpu_reset is high for exactly limit cycles.
  - halt_req -> DONE; that cycle counts.
  - load_start is ignored.
- DONE: cpu_reset=0, done=1; cycle_count and words_loaded are held.
  - load_start -> LOAD; counters clear and done drops.
- busy = state in {LOAD, ARM, RUN}.
- All outputs except im_we/im_addr/im_wdata/ld_ready are registered. Those four are decoded from registered state.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state enum (IDLE, LOAD, ARM, RUN, DONE);
  - default widths ADDR_W/DATA_W/CNT_W;
  - localparam IMEM_DEPTH = 2**ADDR_W.
- No sub-module; a single FSM with two counters.

Test Plan:
1. Reset low for 2 cycles, then high with no load_start -> cpu_reset=0, im_we never 1, busy=0, done=0.
2. load_start; stream 6 words, ld_valid held high, ld_last on word 6, run_cycles=8.
   - Writes at im_addr 0..5 with matching data.
   - words_loaded=6.
   - ARM 1 cycle, then cpu_reset=1 for exactly 8 cycles.
   - done=1, cycle_count=8.
3. ld_valid toggling 1/0 with 4 words; halt_req with word 3 -> words 0..2 written, state IDLE, words_loaded=3, cpu_reset never 1.
4. ADDR_W=2; stream 6 words, no ld_last:
   - exactly 4 writes at addresses 0..3, then ld_ready=0;
   - enters ARM and RUN;
   - words_loaded=4.
5. run_cycles=0; halt_req after 20 run cycles -> done=1, cycle_count=20. A load_start pulsed during RUN has no effect.
6. Reset driven low at RUN cycle 3 -> next edge state IDLE, cpu_reset=0, cycle_count=0. Then load_start from DONE reloads cleanly.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_pkg
//  Description : Shared definitions for the MipsCPU run controller: default
//                widths, instruction memory depth and FSM state encodings.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

   localparam int CPU_ADDR_W = 8;
   localparam int CPU_DATA_W = 32;
   localparam int CPU_CNT_W  = 16;
   localparam int IMEM_DEPTH = 2**CPU_ADDR_W;

   // Controller states; plain constants keep the encoding visible to older tools.
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_LOAD = 3'd1;
   localparam state_t ST_ARM  = 3'd2;
   localparam state_t ST_RUN  = 3'd3;
   localparam state_t ST_DONE = 3'd4;

endpackage
`default_nettype wire

// File: rtl/cpu_boot_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_boot_sequencer
//  Description : Boot/run controller for the single-cycle MIPS CPU. Holds the
//                CPU in reset, streams a program image into instruction memory,
//                releases the CPU for a programmed number of cycles (or until a
//                halt request) and parks it back in reset.
//  Ports       : clock/reset        - clock, synchronous active-low reset
//                load_start         - begin a load (IDLE/DONE only)
//                ld_valid/ld_ready/ld_data/ld_last - image load stream
//                halt_req           - abort load or stop run
//                run_cycles         - run length, 0 = until halt_req
//                im_we/im_addr/im_wdata - instruction memory write port
//                cpu_reset          - active-low reset to MipsCPU
//                busy/done          - status
//                words_loaded/cycle_count - statistics of last load/run
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_boot_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int ADDR_W = CPU_ADDR_W,
   parameter int DATA_W = CPU_DATA_W,
   parameter int CNT_W  = CPU_CNT_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_start,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   input  logic              halt_req,
   input  logic [CNT_W-1:0]  run_cycles,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [DATA_W-1:0] im_wdata,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   words_loaded,
   output logic [CNT_W-1:0]  cycle_count
);

   state_t            state;
   state_t            state_n;
   logic [CNT_W-1:0]  limit;
   logic [ADDR_W:0]   wl_inc;
   logic              beat;

   // words_loaded doubles as the write pointer: its low bits are the next
   // address and its MSB is set once the whole memory has been written.
   assign ld_ready = (state == ST_LOAD) && !words_loaded[ADDR_W];
   assign beat     = ld_valid && ld_ready;
   assign im_we    = beat;
   assign im_addr  = words_loaded[ADDR_W-1:0];
   assign im_wdata = ld_data;
   assign wl_inc   = words_loaded + 1'b1;

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: if (load_start) state_n = ST_LOAD;
         ST_LOAD: begin
            // A halt wins over the move to ARM; a beat in that cycle is still written.
            if (halt_req)
               state_n = ST_IDLE;
            else if (beat && (ld_last || wl_inc[ADDR_W]))
               state_n = ST_ARM;
         end
         ST_ARM:  state_n = ST_RUN;
         ST_RUN: begin
            if (halt_req || ((limit != '0) && (cycle_count == limit - 1'b1)))
               state_n = ST_DONE;
         end
         ST_DONE: if (load_start) state_n = ST_LOAD;
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state        <= ST_IDLE;
         cpu_reset    <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         words_loaded <= '0;
         cycle_count  <= '0;
         limit        <= '0;
      end else begin
         state     <= state_n;
         // Status outputs are registered from the next state so they line up
         // with the state register rather than lagging it by a cycle.
         cpu_reset <= (state_n == ST_RUN);
         busy      <= (state_n == ST_LOAD) || (state_n == ST_ARM) || (state_n == ST_RUN);
         done      <= (state_n == ST_DONE);
         case (state)
            ST_IDLE, ST_DONE: begin
               if (load_start) begin
                  words_loaded <= '0;
                  cycle_count  <= '0;
               end
            end
            ST_LOAD: if (beat) words_loaded <= wl_inc;
            ST_ARM: begin
               limit       <= run_cycles;
               cycle_count <= '0;
            end
            ST_RUN: begin
               // Only reachable in free-run mode; a programmed limit stops first.
               if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
